boss_ctrl: RTL
==============

# boss_ctrl

Parametrised boss controller that replaces the fixed two-player boss datapath with an N-player engine. It holds boss state (idle/chase/enraged/dying/dead), HP with saturating multi-source damage and a hit-cooldown window, aggro-weighted target selection and speed-per-phase movement. It sits between the player/combat logic and the boss renderer, and feeds `boss_x`, `boss_hp`, `boss_alive` and `boss_phase` to render, HUD and the inter-board link.

## Interface
- NUM_PLAYERS, 2, number of player channels (1..8)
- HP_W, 7, HP width
- HP_MAX, 100, HP loaded at start (< 2^HP_W)
- ENRAGE_HP, 40, HP at or below which the boss enrages
- X_START, 512; X_MIN, 64; X_MAX, 960, spawn x and movement clamp (12-bit pixels)
- SPEED1, 2; SPEED2, 4, pixels per frame in CHASE / ENRAGED
- HIT_COOLDOWN, 8, frames of invulnerability after a damaging hit
- DYING_FRAMES, 60, frames spent in DYING

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- game_active  in  1  level; low forces IDLE
- game_start  in  1  one-cycle pulse
- frame_tick  in  1  one-cycle pulse per video frame
- player_x  in  12*NUM_PLAYERS  packed player x, channel i at [12i+:12]
- player_aggro  in  4*NUM_PLAYERS  packed aggro weights
- player_valid  in  NUM_PLAYERS  channel present/alive
- hit  in  NUM_PLAYERS  per-channel one-cycle hit strobe
- hit_dmg  in  4*NUM_PLAYERS  packed damage per hit
- ext_hp_valid  in  1  remote HP update strobe
- ext_hp  in  HP_W  remote HP value
- boss_x  out  12  boss x position
- boss_hp  out  HP_W  current HP
- boss_alive  out  1  high in CHASE/ENRAGED
- boss_phase  out  3  one-hot {dead/dying, enraged, chase}; 0 in IDLE
- target_idx  out  $clog2(NUM_PLAYERS) (min 1)  current target channel

## Operation
- Reset values: state IDLE, boss_x=X_START, boss_hp=HP_MAX, boss_alive=0, boss_phase=0, target_idx=0, cooldown=0, dying counter=0.
- IDLE: hold reset values; game_start with game_active high -> CHASE.
- CHASE: boss_hp <= ENRAGE_HP -> ENRAGED; boss_hp==0 -> DYING (priority over enrage).
- ENRAGED: boss_hp==0 -> DYING. No return to CHASE (ext_hp rise does not de-enrage).
- DYING: counter counts frame_ticks; after DYING_FRAMES ticks -> DEAD.
- DEAD: game_start -> reload HP_MAX, X_START, cooldown 0, -> CHASE.
- game_active low in any state -> IDLE next cycle with reset values; overrides all else.
- Damage (CHASE/ENRAGED only, cooldown==0): sum = Σ hit_dmg[i] over asserted hit[i] (width HP_W+log2 N+4, no overflow); boss_hp <= (sum >= boss_hp) ? 0 : boss_hp - sum. If sum>0, cooldown <= HIT_COOLDOWN. Hits during cooldown or other states are dropped, not queued.
- ext_hp_valid (any state except IDLE): boss_hp <= min(ext_hp, HP_MAX); wins over local damage that cycle; does not touch cooldown.
- Cooldown decrements on frame_tick when nonzero; a damage cycle that coincides with frame_tick loads HIT_COOLDOWN (no decrement).
- Target: on frame_tick, target_idx <= valid channel with the highest aggro; ties -> lowest index; none valid -> target_idx held, no movement this frame.
- Movement on frame_tick in CHASE (SPEED1) / ENRAGED (SPEED2): dx = target_x - boss_x (signed 13-bit); |dx| <= speed -> boss_x <= target_x; else step by speed toward target; result clamped to [X_MIN, X_MAX]. Movement uses the target chosen in the same tick (combinational select, registered result). No movement in IDLE/DYING/DEAD.

## Timing
- All outputs registered; hit or ext_hp_valid at cycle N -> boss_hp updated at N+1.
- boss_hp reaching 0 at N+1 -> state DYING, boss_alive=0, boss_phase=3'b100 at N+2.
- Enrage threshold crossed at N+1 -> boss_phase=3'b010 at N+2.
- frame_tick at N -> boss_x and target_idx valid at N+1.
- game_start at N in IDLE/DEAD -> CHASE, boss_alive=1 at N+1. game_start in CHASE/ENRAGED/DYING ignored.
- rst assertion mid-operation: outputs return to reset values immediately (asynchronous).

## Test plan
- Reset, game_active=1, game_start -> boss_alive=1, boss_phase=001, boss_hp=100, boss_x=512 one cycle later.
- P0 x=600 aggro 2, P1 x=400 aggro 5, both valid; 3 frame_ticks -> target_idx=1, boss_x 510, 508, 506.
- hit[0] dmg 5 and hit[1] dmg 7 same cycle -> boss_hp 88; further hit within 8 frames dropped; hit after 8th tick -> applied.
- Damage to hp=40 -> boss_phase=010; next frames move 4 px; target 3 px away -> boss_x snaps to target; target_x=20 -> boss_x clamps at 64.
- boss_hp=3, hit dmg 15 -> boss_hp=0, DYING, boss_alive=0; 60 frame_ticks -> DEAD; game_start -> hp=100, x=512, CHASE.
- ext_hp_valid ext_hp=120 with simultaneous hit -> boss_hp=100, hit ignored; game_active low mid-ENRAGED -> IDLE, hp=100 next cycle.

Source files
------------

// File: rtl/boss_ctrl_if.sv
// boss_ctrl_if: bus between the player/combat side (master) and the boss engine (slave).
// Master drives:
//   game state:    game_active, game_start, frame_tick
//   player bus:    player_x, player_aggro, player_valid
//   combat bus:    hit, hit_dmg
//   remote HP:     ext_hp_valid, ext_hp
// Slave drives:
//   boss_x, boss_hp, boss_alive, boss_phase, target_idx
interface boss_ctrl_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int HP_W        = 7
);
    localparam int TW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    logic                     game_active;
    logic                     game_start;
    logic                     frame_tick;
    logic [12*NUM_PLAYERS-1:0] player_x;
    logic [4*NUM_PLAYERS-1:0]  player_aggro;
    logic [NUM_PLAYERS-1:0]    player_valid;
    logic [NUM_PLAYERS-1:0]    hit;
    logic [4*NUM_PLAYERS-1:0]  hit_dmg;
    logic                     ext_hp_valid;
    logic [HP_W-1:0]          ext_hp;
    logic [11:0]              boss_x;
    logic [HP_W-1:0]          boss_hp;
    logic                     boss_alive;
    logic [2:0]               boss_phase;
    logic [TW-1:0]            target_idx;
    modport master (
        output game_active, game_start, frame_tick, player_x, player_aggro, player_valid,
               hit, hit_dmg, ext_hp_valid, ext_hp,
        input  boss_x, boss_hp, boss_alive, boss_phase, target_idx
    );
    modport slave (
        input  game_active, game_start, frame_tick, player_x, player_aggro, player_valid,
               hit, hit_dmg, ext_hp_valid, ext_hp,
        output boss_x, boss_hp, boss_alive, boss_phase, target_idx
    );
endinterface

// File: rtl/boss_ctrl.sv
// boss_ctrl: N-player boss engine -- phase FSM, saturating multi-hit HP with cooldown,
// aggro-weighted targeting and per-phase chase movement.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   bus     boss_ctrl_if slave: game/player/combat inputs, boss state outputs
module boss_ctrl #(
    parameter int NUM_PLAYERS  = 2,
    parameter int HP_W         = 7,
    parameter int HP_MAX       = 100,
    parameter int ENRAGE_HP    = 40,
    parameter int X_START      = 512,
    parameter int X_MIN        = 64,
    parameter int X_MAX        = 960,
    parameter int SPEED1       = 2,
    parameter int SPEED2       = 4,
    parameter int HIT_COOLDOWN = 8,
    parameter int DYING_FRAMES = 60
) (
    input logic        clk_i,
    input logic        rst_ni,
    boss_ctrl_if.slave bus
);
    localparam int TW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int SW = HP_W + $clog2(NUM_PLAYERS) + 4;
    localparam int CW = $clog2(HIT_COOLDOWN + 1);
    localparam int DW = $clog2(DYING_FRAMES + 1);
    localparam logic [HP_W-1:0]   HPM = HP_W'(HP_MAX);
    localparam logic [HP_W-1:0]   ENR = HP_W'(ENRAGE_HP);
    localparam logic [DW-1:0]     DF1 = DW'(DYING_FRAMES - 1);
    localparam logic signed [13:0] XMN = 14'(X_MIN);
    localparam logic signed [13:0] XMX = 14'(X_MAX);

    typedef enum logic [2:0] {IDLE, CHASE, ENRAGED, DYING, DEAD} state_t;
    state_t state_q, state_d;
    logic [11:0]   x_q, x_d, tx, x_mv;
    logic [HP_W-1:0] hp_q, hp_d;
    logic [CW-1:0] cd_q, cd_d;
    logic [DW-1:0] dc_q, dc_d;
    logic [TW-1:0] tg_q, tg_d, best;
    logic [3:0]    best_ag;
    logic [SW-1:0] sum;
    logic          any_v, alive, dmg;
    logic [2:0]    phase;
    logic signed [13:0] dx, adx, spd, nx;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // game_active low overrides every other transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.game_start) state_d = CHASE;
            CHASE:   state_d = (hp_q == '0) ? DYING : (hp_q <= ENR) ? ENRAGED : CHASE;
            ENRAGED: if (hp_q == '0) state_d = DYING;
            DYING:   if (bus.frame_tick && dc_q == DF1) state_d = DEAD;
            DEAD:    if (bus.game_start) state_d = CHASE;
            default: state_d = IDLE;
        endcase
        if (!bus.game_active) state_d = IDLE;
    end

    always_comb begin
        alive = (state_q == CHASE) || (state_q == ENRAGED);
        phase = {(state_q == DYING) || (state_q == DEAD), state_q == ENRAGED, state_q == CHASE};
    end

    // strict '>' keeps the lowest index on aggro ties
    always_comb begin
        any_v   = 1'b0;
        best    = '0;
        best_ag = '0;
        tx      = '0;
        sum     = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (bus.player_valid[i] && (!any_v || bus.player_aggro[4*i +: 4] > best_ag)) begin
                any_v   = 1'b1;
                best    = TW'(i);
                best_ag = bus.player_aggro[4*i +: 4];
                tx      = bus.player_x[12*i +: 12];
            end
            if (bus.hit[i]) sum = sum + SW'(bus.hit_dmg[4*i +: 4]);
        end
    end

    always_comb begin
        spd  = (state_q == ENRAGED) ? 14'(SPEED2) : 14'(SPEED1);
        dx   = $signed({2'b00, tx}) - $signed({2'b00, x_q});
        adx  = dx[13] ? -dx : dx;
        nx   = (adx <= spd) ? $signed({2'b00, tx}) :
               dx[13] ? $signed({2'b00, x_q}) - spd : $signed({2'b00, x_q}) + spd;
        x_mv = (nx < XMN) ? 12'(X_MIN) : (nx > XMX) ? 12'(X_MAX) : nx[11:0];
    end

    always_comb begin
        x_d  = x_q;
        hp_d = hp_q;
        cd_d = cd_q;
        dc_d = dc_q;
        tg_d = tg_q;
        dmg  = alive && cd_q == '0 && sum != '0 && !bus.ext_hp_valid;
        if (!bus.game_active || state_q == IDLE) begin
            x_d  = 12'(X_START);
            hp_d = HPM;
            cd_d = '0;
            dc_d = '0;
            tg_d = '0;
        end else if (state_q == DEAD && bus.game_start) begin
            x_d  = 12'(X_START);
            hp_d = HPM;
            cd_d = '0;
            dc_d = '0;
        end else begin
            if (bus.frame_tick && any_v) tg_d = best;
            if (bus.frame_tick && any_v && alive) x_d = x_mv;
            if (bus.frame_tick && state_q == DYING) dc_d = dc_q + 1'b1;
            // remote HP is authoritative and suppresses local damage that cycle
            if (bus.ext_hp_valid) hp_d = (bus.ext_hp > HPM) ? HPM : bus.ext_hp;
            else if (dmg) hp_d = (sum >= SW'(hp_q)) ? '0 : hp_q - sum[HP_W-1:0];
            if (dmg) cd_d = CW'(HIT_COOLDOWN);
            else if (bus.frame_tick && cd_q != '0) cd_d = cd_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q  <= 12'(X_START);
            hp_q <= HPM;
            cd_q <= '0;
            dc_q <= '0;
            tg_q <= '0;
        end else begin
            x_q  <= x_d;
            hp_q <= hp_d;
            cd_q <= cd_d;
            dc_q <= dc_d;
            tg_q <= tg_d;
        end
    end

    assign bus.boss_x     = x_q;
    assign bus.boss_hp    = hp_q;
    assign bus.boss_alive = alive;
    assign bus.boss_phase = phase;
    assign bus.target_idx = tg_q;
endmodule
